// File: rtl/telemetry_framer_pkg.sv
// Shared framing constants for the telemetry framer and its host-side parser:
// FSM state encodings, default sync bytes and per-frame overhead.
package telemetry_framer_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_SYNC0 = 3'd1;
    localparam logic [STATE_W-1:0] ST_SYNC1 = 3'd2;
    localparam logic [STATE_W-1:0] ST_SEQ   = 3'd3;
    localparam logic [STATE_W-1:0] ST_DATA  = 3'd4;
    localparam logic [STATE_W-1:0] ST_CSUM  = 3'd5;

    localparam logic [7:0] DEF_SYNC0 = 8'hAA;
    localparam logic [7:0] DEF_SYNC1 = 8'h55;

    // SYNC0 + SYNC1 + SEQ + CSUM; frame length is DATA_BYTES + this
    localparam int unsigned FRAME_OVERHEAD = 4;

endpackage

// File: rtl/telemetry_framer_if.sv
// Sample input and UART write port of the telemetry framer.
// master = framer side, slave = sample source / UART side.
interface telemetry_framer_if #(
    parameter int unsigned SAMPLE_W = 32
);
    logic                i_sample_valid;
    logic [SAMPLE_W-1:0] i_sample_data;
    logic                i_uart_full;
    logic                o_uart_wr;
    logic [7:0]          o_uart_data;

    modport master (
        input  i_sample_valid, i_sample_data, i_uart_full,
        output o_uart_wr, o_uart_data
    );

    modport slave (
        output i_sample_valid, i_sample_data, i_uart_full,
        input  o_uart_wr, o_uart_data
    );
endinterface

// File: rtl/telemetry_framer.sv
// Frames telemetry words into SYNC0 SYNC1 SEQ DATA.. CSUM bytes for uart_top,
// with a one-deep holding buffer and a saturating overrun counter.
module telemetry_framer
    import telemetry_framer_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 32,
    parameter int unsigned DATA_BYTES = 4,
    parameter logic [7:0]  SYNC0      = DEF_SYNC0,
    parameter logic [7:0]  SYNC1      = DEF_SYNC1
) (
    input  logic                Clk,
    input  logic                debounced_reset,
    telemetry_framer_if.master  bus,
    output logic                o_busy,
    output logic [7:0]          o_drop_count
);

    localparam int unsigned IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    logic [STATE_W-1:0]  state_q,    state_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [SAMPLE_W-1:0] hold_q,     hold_d;
    logic                pending_q,  pending_d;
    logic [SAMPLE_W-1:0] frame_q,    frame_d;
    logic [7:0]          csum_q,     csum_d;
    logic [7:0]          seq_q,      seq_d;
    logic [7:0]          drop_q,     drop_d;

    logic       wr;
    logic       take;
    logic [7:0] data_byte;
    logic [7:0] uart_byte;

    assign wr   = (state_q != ST_IDLE) && !bus.i_uart_full;
    assign take = (state_q == ST_IDLE) && pending_q;

    always_comb begin
        data_byte = '0;
        for (int unsigned k = 0; k < DATA_BYTES; k++) begin
            if (byte_idx_q == IDX_W'(k)) data_byte = frame_q[8*k +: 8];
        end
    end

    // csum_q holds the running sum; the transmitted byte is its negation
    always_comb begin
        case (state_q)
            ST_SYNC0: uart_byte = SYNC0;
            ST_SYNC1: uart_byte = SYNC1;
            ST_SEQ:   uart_byte = seq_q;
            ST_DATA:  uart_byte = data_byte;
            ST_CSUM:  uart_byte = 8'd0 - csum_q;
            default:  uart_byte = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        hold_d     = hold_q;
        pending_d  = pending_q;
        frame_d    = frame_q;
        csum_d     = csum_q;
        seq_d      = seq_q;
        drop_d     = drop_q;

        if (take) begin
            frame_d    = hold_q;
            csum_d     = '0;
            byte_idx_d = '0;
            pending_d  = 1'b0;
            state_d    = ST_SYNC0;
        end

        if (wr) begin
            case (state_q)
                ST_SYNC0: state_d = ST_SYNC1;
                ST_SYNC1: state_d = ST_SEQ;
                ST_SEQ: begin
                    csum_d  = csum_q + seq_q;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    csum_d = csum_q + data_byte;
                    if (byte_idx_q == IDX_W'(DATA_BYTES - 1)) state_d = ST_CSUM;
                    else                                       byte_idx_d = byte_idx_q + 1'b1;
                end
                ST_CSUM: begin
                    seq_d   = seq_q + 8'd1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A word arriving on the transfer edge refills the buffer without counting a drop
        if (bus.i_sample_valid) begin
            hold_d    = bus.i_sample_data;
            pending_d = 1'b1;
            if (pending_q && !take && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge debounced_reset) begin
        if (!debounced_reset) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            hold_q     <= '0;
            pending_q  <= 1'b0;
            frame_q    <= '0;
            csum_q     <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            frame_q    <= frame_d;
            csum_q     <= csum_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.o_uart_wr   = wr;
    assign bus.o_uart_data = uart_byte;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_drop_count    = drop_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed self-checking bench for telemetry_framer: framing, stalls, overruns,
// sequence wrap, drop saturation and mid-frame reset.
module tb_telemetry_framer;

    logic       Clk = 1'b0;
    logic       debounced_reset = 1'b0;
    logic       o_busy;
    logic [7:0] o_drop_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] q[$];
    int         tq[$];

    telemetry_framer_if #(.SAMPLE_W(32)) bus ();

    telemetry_framer #(
        .SAMPLE_W  (32),
        .DATA_BYTES(4),
        .SYNC0     (8'hAA),
        .SYNC1     (8'h55)
    ) dut (
        .Clk            (Clk),
        .debounced_reset(debounced_reset),
        .bus            (bus.master),
        .o_busy         (o_busy),
        .o_drop_count   (o_drop_count)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (bus.o_uart_wr) begin
            q.push_back(bus.o_uart_data);
            tq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(posedge Clk);
        #1;
        debounced_reset    = 1'b0;
        bus.i_sample_valid = 1'b0;
        bus.i_uart_full    = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        debounced_reset = 1'b1;
        q.delete();
        tq.delete();
    endtask

    // valid is sampled on the second edge; vc = cycle number of that edge
    task automatic send_sample(input logic [31:0] w, output int vc);
        @(posedge Clk);
        #1;
        bus.i_sample_valid = 1'b1;
        bus.i_sample_data  = w;
        @(posedge Clk);
        #1;
        vc = cyc;
        bus.i_sample_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (q.size() < n && t < 300) begin
            @(posedge Clk);
            t++;
        end
        #1;
        chk("nbytes", q.size(), n);
    endtask

    task automatic expect_frame(input int base, input logic [7:0] seq, input logic [31:0] w);
        int unsigned sum;
        logic [7:0] b;
        sum = seq;
        chk("sync0", q[base], 8'hAA);
        chk("sync1", q[base+1], 8'h55);
        chk("seq", q[base+2], seq);
        for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            sum += b;
            chk("data", q[base+3+k], b);
        end
        chk("csum", q[base+7], (256 - (sum % 256)) % 256);
    endtask

    initial begin
        int vc;
        int dummy;
        logic [31:0] w;

        bus.i_sample_valid = 1'b0;
        bus.i_sample_data  = '0;
        bus.i_uart_full    = 1'b0;
        #2;
        chk("rst_wr", bus.o_uart_wr, 0);
        chk("rst_data", bus.o_uart_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_drop", o_drop_count, 0);
        apply_reset();

        // 1: single frame, latency and back-to-back strobes
        send_sample(32'h0064_00C8, vc);
        wait_bytes(1);
        chk("busy_mid", o_busy, 1);
        wait_bytes(8);
        chk("t1_b0", q[0], 8'hAA);
        chk("t1_b1", q[1], 8'h55);
        chk("t1_b2", q[2], 8'h00);
        chk("t1_b3", q[3], 8'hC8);
        chk("t1_b4", q[4], 8'h00);
        chk("t1_b5", q[5], 8'h64);
        chk("t1_b6", q[6], 8'h00);
        chk("t1_b7", q[7], 8'hD4);
        chk("t1_lat", tq[0] - vc, 1);
        chk("t1_span", tq[7] - tq[0], 7);
        chk("t1_idle", o_busy, 0);

        // 2: stall on DATA byte 1
        apply_reset();
        send_sample(32'h0064_00C8, vc);
        begin
            int t = 0;
            while (q.size() < 4 && t < 50) begin
                @(posedge Clk);
                t++;
            end
        end
        #1;
        bus.i_uart_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("t2_nowr", bus.o_uart_wr, 0);
            chk("t2_hold", bus.o_uart_data, 8'h00);
        end
        @(posedge Clk);
        #1;
        bus.i_uart_full = 1'b0;
        chk("t2_cnt", q.size(), 4);
        wait_bytes(8);
        expect_frame(0, 8'h00, 32'h0064_00C8);
        chk("t2_csum", q[7], 8'hD4);

        // 3: overrun during a frame drops the middle word
        apply_reset();
        send_sample(32'h1111_1111, vc);
        send_sample(32'h2222_2222, vc);
        send_sample(32'h3333_3333, vc);
        wait_bytes(16);
        expect_frame(0, 8'h00, 32'h1111_1111);
        expect_frame(8, 8'h01, 32'h3333_3333);
        chk("t3_drop", o_drop_count, 1);

        // 4: valid on the transfer edge
        apply_reset();
        @(posedge Clk);
        #1;
        bus.i_sample_valid = 1'b1;
        bus.i_sample_data  = 32'hDEAD_BEEF;
        @(posedge Clk);
        #1;
        bus.i_sample_data  = 32'h0102_0304;
        @(posedge Clk);
        #1;
        bus.i_sample_valid = 1'b0;
        wait_bytes(16);
        expect_frame(0, 8'h00, 32'hDEAD_BEEF);
        expect_frame(8, 8'h01, 32'h0102_0304);
        chk("t4_drop", o_drop_count, 0);

        // 5: sequence wrap over 257 frames, then drop saturation
        apply_reset();
        for (int i = 0; i < 257; i++) begin
            w = {i[7:0], 8'h5A, ~i[7:0], 8'h3C};
            send_sample(w, vc);
            wait_bytes(8 * (i + 1));
            expect_frame(8 * i, i[7:0], w);
        end
        chk("t5_nodrop", o_drop_count, 0);
        @(posedge Clk);
        #1;
        bus.i_uart_full    = 1'b1;
        bus.i_sample_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.i_sample_data = i;
            @(posedge Clk);
            #1;
        end
        bus.i_sample_valid = 1'b0;
        chk("t5_sat", o_drop_count, 8'hFF);

        // 6: reset in the middle of DATA
        apply_reset();
        bus.i_uart_full = 1'b1;
        send_sample(32'hAAAA_0001, vc);
        send_sample(32'hAAAA_0002, vc);
        send_sample(32'hAAAA_0003, vc);
        chk("t6_drop_pre", o_drop_count, 1);
        bus.i_uart_full = 1'b0;
        begin
            int t = 0;
            while (q.size() < 4 && t < 50) begin
                @(posedge Clk);
                t++;
            end
        end
        #1;
        chk("t6_wr_pre", bus.o_uart_wr, 1);
        debounced_reset = 1'b0;
        #1;
        chk("t6_wr_async", bus.o_uart_wr, 0);
        chk("t6_busy_async", o_busy, 0);
        repeat (2) @(posedge Clk);
        #1;
        debounced_reset = 1'b1;
        q.delete();
        tq.delete();
        repeat (3) @(posedge Clk);
        #1;
        chk("t6_noframe", q.size(), 0);
        chk("t6_drop", o_drop_count, 0);
        send_sample(32'h0064_00C8, dummy);
        wait_bytes(8);
        expect_frame(0, 8'h00, 32'h0064_00C8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
